mem_arbiter: RTL and testbench

//   Shares one memory2c array between the instruction-fetch port (I) and the data port (D).

---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side signals shared by mem_arbiter and its clients.
// slave is the arbiter view; master is the requester-plus-memory view.
interface mem_arbiter_if;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_done;
    logic        i_stall;

    logic        d_req;
    logic        d_wr;
    logic        d_dump;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        d_stall;

    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic        mem_enable;
    logic        mem_wr;
    logic        mem_createdump;
    logic [15:0] mem_data_out;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_done, i_stall,
        input  d_req, d_wr, d_dump, d_addr, d_wdata,
        output d_rdata, d_done, d_stall,
        output mem_addr, mem_data_in, mem_enable, mem_wr, mem_createdump,
        input  mem_data_out
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_done, i_stall,
        output d_req, d_wr, d_dump, d_addr, d_wdata,
        input  d_rdata, d_done, d_stall,
        input  mem_addr, mem_data_in, mem_enable, mem_wr, mem_createdump,
        output mem_data_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one unified memory, running each
// access through a fixed MEM_LAT-cycle window followed by a one-cycle done pulse.
module mem_arbiter #(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic          err
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q;
    logic [2:0]  starve_q;
    logic [2:0]  lat_q;
    logic        owner_d_q;
    logic        nodata_q;
    logic [15:0] mem_addr_q;
    logic [15:0] mem_din_q;
    logic        mem_en_q;
    logic        mem_wr_q;
    logic        mem_dump_q;
    logic [15:0] i_rdata_q;
    logic [15:0] d_rdata_q;
    logic        i_done_q;
    logic        d_done_q;
    logic        err_q;

    logic        starved;
    logic        grant_i;
    logic        grant_d;
    logic [15:0] grant_addr;
    logic        grant_err;
    logic        last_beat;

    always_comb begin
        starved    = (starve_q == 3'(STARVE_MAX));
        grant_i    = bus.i_req & (~bus.d_req | starved);
        grant_d    = bus.d_req & ~grant_i;
        grant_addr = grant_i ? bus.i_addr : bus.d_addr;
        grant_err  = grant_addr[0] | (grant_d & bus.d_wr & bus.d_dump);
        last_beat  = (lat_q == 3'(MEM_LAT - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            starve_q   <= 3'd0;
            lat_q      <= 3'd0;
            owner_d_q  <= 1'b0;
            nodata_q   <= 1'b0;
            mem_addr_q <= 16'h0000;
            mem_din_q  <= 16'h0000;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_dump_q <= 1'b0;
            i_rdata_q  <= 16'h0000;
            d_rdata_q  <= 16'h0000;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Count D wins that left I waiting; saturates because I wins at the limit.
                    if (grant_d && bus.i_req) begin
                        if (!starved) starve_q <= starve_q + 3'd1;
                    end else begin
                        starve_q <= 3'd0;
                    end
                    if (grant_i || grant_d) begin
                        state_q    <= StAccess;
                        lat_q      <= 3'd0;
                        owner_d_q  <= grant_d;
                        nodata_q   <= grant_d & (bus.d_wr | bus.d_dump);
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= grant_addr;
                        mem_din_q  <= grant_d ? bus.d_wdata : 16'h0000;
                        mem_wr_q   <= grant_d & bus.d_wr;
                        mem_dump_q <= grant_d & bus.d_dump;
                        if (grant_err) err_q <= 1'b1;
                    end
                end
                StAccess: begin
                    mem_wr_q   <= 1'b0;
                    mem_dump_q <= 1'b0;
                    if (last_beat) begin
                        state_q    <= StResp;
                        mem_en_q   <= 1'b0;
                        mem_addr_q <= 16'h0000;
                        mem_din_q  <= 16'h0000;
                        if (owner_d_q) begin
                            d_rdata_q <= nodata_q ? 16'h0000 : bus.mem_data_out;
                            d_done_q  <= 1'b1;
                        end else begin
                            i_rdata_q <= bus.mem_data_out;
                            i_done_q  <= 1'b1;
                        end
                    end else begin
                        lat_q <= lat_q + 3'd1;
                    end
                end
                StResp: begin
                    i_done_q <= 1'b0;
                    d_done_q <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.i_rdata        = i_rdata_q;
    assign bus.i_done         = i_done_q;
    assign bus.i_stall        = bus.i_req & ~i_done_q;
    assign bus.d_rdata        = d_rdata_q;
    assign bus.d_done         = d_done_q;
    assign bus.d_stall        = bus.d_req & ~d_done_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_data_in    = mem_din_q;
    assign bus.mem_enable     = mem_en_q;
    assign bus.mem_wr         = mem_wr_q;
    assign bus.mem_createdump = mem_dump_q;
    assign err                = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: MEM_LAT=1 instance for function/arbitration/errors,
// MEM_LAT=3 instance for the longer access window.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err1;
    logic err3;

    always #5 clk = ~clk;

    mem_arbiter_if bus1();
    mem_arbiter_if bus3();

    mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave), .err(err1)
    );
    mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3.slave), .err(err3)
    );

    // Memory models: combinational read, clocked write, plus a bench preload port.
    logic [15:0] mem1 [0:255];
    logic [15:0] mem3 [0:255];
    logic        ld_en = 1'b0;
    logic [7:0]  ld_a  = 8'h00;
    logic [15:0] ld_d  = 16'h0000;

    assign bus1.mem_data_out = mem1[bus1.mem_addr[7:0]];
    assign bus3.mem_data_out = mem3[bus3.mem_addr[7:0]];

    always @(posedge clk) begin
        if (ld_en) mem1[ld_a] <= ld_d;
        else if (bus1.mem_enable && bus1.mem_wr) mem1[bus1.mem_addr[7:0]] <= bus1.mem_data_in;
    end
    always @(posedge clk) begin
        if (ld_en) mem3[ld_a] <= ld_d;
        else if (bus3.mem_enable && bus3.mem_wr) mem3[bus3.mem_addr[7:0]] <= bus3.mem_data_in;
    end

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        is_d;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    int wr_cycles   = 0;
    int dump_cycles = 0;
    int wr3_cycles  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus1.mem_wr) wr_cycles++;
        if (bus1.mem_createdump) dump_cycles++;
        if (bus3.mem_wr) wr3_cycles++;
    end

    // Scoreboard: every done must match the oldest expected (port, data).
    always @(negedge clk) begin
        if (bus1.i_done || bus1.d_done) begin
            exp_t e;
            check_eq("one_done", 32'(bus1.i_done & bus1.d_done), 0);
            check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("done_port", 32'(bus1.d_done), 32'(e.is_d));
                check_eq("rdata", 32'(e.is_d ? bus1.d_rdata : bus1.i_rdata), 32'(e.data));
            end
        end
    end

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_a = a; ld_d = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic expect_done(input logic is_d, input logic [15:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic xfer(input logic is_d, input logic wr, input logic dump,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp);
        logic got;
        expect_done(is_d, exp);
        @(posedge clk); #1;
        if (is_d) begin
            bus1.d_req = 1'b1; bus1.d_wr = wr; bus1.d_dump = dump;
            bus1.d_addr = addr; bus1.d_wdata = wdata;
        end else begin
            bus1.i_req = 1'b1; bus1.i_addr = addr;
        end
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = is_d ? bus1.d_done : bus1.i_done;
        end
        check_eq("done_seen", 32'(got), 1);
        @(posedge clk); #1;
        bus1.i_req = 1'b0; bus1.d_req = 1'b0; bus1.d_wr = 1'b0; bus1.d_dump = 1'b0;
    endtask

    initial begin
        int w0;
        int seen;
        bus1.i_req = 1'b0; bus1.i_addr = 16'h0; bus1.d_req = 1'b0; bus1.d_wr = 1'b0;
        bus1.d_dump = 1'b0; bus1.d_addr = 16'h0; bus1.d_wdata = 16'h0;
        bus3.i_req = 1'b0; bus3.i_addr = 16'h0; bus3.d_req = 1'b0; bus3.d_wr = 1'b0;
        bus3.d_dump = 1'b0; bus3.d_addr = 16'h0; bus3.d_wdata = 16'h0;

        load(8'h10, 16'hA5A5);
        load(8'h20, 16'h1111);
        load(8'h30, 16'h2222);
        load(8'h03, 16'h0BAD);
        load(8'h40, 16'h7777);
        @(negedge clk);
        check_eq("rst_en", 32'(bus1.mem_enable), 0);
        check_eq("rst_done", 32'({bus1.i_done, bus1.d_done}), 0);
        check_eq("rst_err", 32'(err1), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Single fetch with cycle-exact latency and stall.
        expect_done(1'b0, 16'hA5A5);
        @(posedge clk); #1;
        bus1.i_req = 1'b1; bus1.i_addr = 16'h0010;
        @(negedge clk);
        check_eq("f_stall_t0", 32'(bus1.i_stall), 1);
        check_eq("f_en_t0", 32'(bus1.mem_enable), 0);
        @(negedge clk);
        check_eq("f_en_t1", 32'(bus1.mem_enable), 1);
        check_eq("f_addr_t1", 32'(bus1.mem_addr), 32'h0010);
        check_eq("f_stall_t1", 32'(bus1.i_stall), 1);
        @(negedge clk);
        check_eq("f_done_t2", 32'(bus1.i_done), 1);
        check_eq("f_rdata_t2", 32'(bus1.i_rdata), 32'hA5A5);
        check_eq("f_stall_t2", 32'(bus1.i_stall), 0);
        check_eq("f_en_t2", 32'(bus1.mem_enable), 0);
        @(posedge clk); #1;
        bus1.i_req = 1'b0;

        // Write then read back on D, and via I through the shared array.
        w0 = wr_cycles;
        xfer(1'b1, 1'b1, 1'b0, 16'h0004, 16'h1234, 16'h0000);
        check_eq("wr_one_cycle", 32'(wr_cycles - w0), 1);
        xfer(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'h1234);
        xfer(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'h1234);
        w0 = dump_cycles;
        xfer(1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h0000);
        check_eq("dump_one_cycle", 32'(dump_cycles - w0), 1);
        check_eq("no_err", 32'(err1), 0);

        // Contention: expect D,D,D,D,I repeated.
        for (int k = 0; k < 10; k++)
            expect_done((k % 5) != 4, ((k % 5) != 4) ? 16'h1111 : 16'h2222);
        @(posedge clk); #1;
        bus1.d_addr = 16'h0020; bus1.i_addr = 16'h0030;
        bus1.d_req = 1'b1; bus1.i_req = 1'b1;
        seen = 0;
        for (int n = 0; n < 200 && seen < 10; n++) begin
            @(negedge clk);
            if (bus1.i_done || bus1.d_done) seen++;
        end
        bus1.d_req = 1'b0; bus1.i_req = 1'b0;
        check_eq("contention_cnt", 32'(seen), 10);
        repeat (3) @(posedge clk);
        check_eq("sb_drained", 32'(sb.size()), 0);

        // Error: write+dump sets err, which stays after later clean accesses.
        xfer(1'b1, 1'b1, 1'b1, 16'h0008, 16'hBEEF, 16'h0000);
        check_eq("err_wr_dump", 32'(err1), 1);
        xfer(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1111);
        check_eq("err_sticky", 32'(err1), 1);

        // Reset mid-ACCESS drops the access and clears everything.
        @(posedge clk); #1;
        bus1.i_req = 1'b1; bus1.i_addr = 16'h0010;
        @(posedge clk); #1;
        check_eq("pre_rst_en", 32'(bus1.mem_enable), 1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_en", 32'(bus1.mem_enable), 0);
        check_eq("mid_rst_addr", 32'(bus1.mem_addr), 0);
        check_eq("mid_rst_rdata", 32'({bus1.i_rdata, bus1.d_rdata}), 0);
        check_eq("mid_rst_err", 32'(err1), 0);
        bus1.i_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        xfer(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5A5);
        check_eq("post_rst_err", 32'(err1), 0);
        xfer(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 16'h0BAD);
        check_eq("err_misalign", 32'(err1), 1);

        // MEM_LAT=3 read on the second instance.
        @(posedge clk); #1;
        bus3.d_req = 1'b1; bus3.d_addr = 16'h0030;
        @(negedge clk);
        check_eq("l3_en_t0", 32'(bus3.mem_enable), 0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_eq("l3_en_win", 32'(bus3.mem_enable), 1);
            check_eq("l3_nodone", 32'(bus3.d_done), 0);
        end
        @(negedge clk);
        check_eq("l3_done_t4", 32'(bus3.d_done), 1);
        check_eq("l3_rdata", 32'(bus3.d_rdata), 32'h2222);
        check_eq("l3_en_t4", 32'(bus3.mem_enable), 0);
        @(posedge clk); #1;
        bus3.d_req = 1'b0;
        @(negedge clk);
        check_eq("l3_done_off", 32'(bus3.d_done), 0);
        check_eq("l3_never_wr", 32'(wr3_cycles), 0);
        check_eq("sb_final", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
